static_priority_issue_queue: RTL and testbench
==============================================

Name: static_priority_issue_queue

Overview:
Multi-port entry buffer built around the StaticPrioritySelector masks. It owns the per-entry valid and payload storage, and writes up to EnqWidth new entries per cycle into the lowest-index free slots. Each cycle it issues up to SelWidth entries, choosing the lowest-index ones that are both valid and externally marked ready. It sits between rename/dispatch (the enqueue side) and the execution pipes (the issue side), acting as the storage and handshake end of the allocation/selection masks.

Parameters:
Depth, 8, number of entries; must be at least EnqWidth and at least SelWidth.
EnqWidth, 2, number of enqueue ports.
SelWidth, 2, number of issue (dequeue) ports.
DataWidth, 32, payload bits per entry.
PtrWidth, $clog2(Depth), width of an entry index (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush_i  input  1  invalidates all entries at the next edge.
enq_vld_i  input  EnqWidth  per-port enqueue request.
enq_data_i  input  EnqWidth*DataWidth  enqueue payload; port k occupies bits [k*DataWidth +: DataWidth].
enq_rdy_o  output  EnqWidth  port k has a free slot assigned to it.
entry_rdy_i  input  Depth  per-entry operand-ready vector from wakeup logic.
deq_vld_o  output  SelWidth  issue port j presents an entry.
deq_rdy_i  input  SelWidth  consumer accepts issue port j.
deq_data_o  output  SelWidth*DataWidth  payload of the selected entry.
deq_idx_o  output  SelWidth*PtrWidth  index of the selected entry.
entry_vld_o  output  Depth  registered valid bits.
count_o  output  PtrWidth+1  number of valid entries.
full_o  output  1  count_o equals Depth.
empty_o  output  1  count_o equals 0.

Behaviour:
- Reset (asynchronous, rst_n=0): all valid bits and all payloads cleared to 0; count_o=0.
  - Resulting outputs: empty_o=1, full_o=0, deq_vld_o=0, deq_data_o=0, deq_idx_o=0.
  - enq_rdy_o is all ones, since Depth is at least EnqWidth.
  - Asserting reset mid-operation discards all entries immediately; no partial write survives.
- Enqueue allocation:
  - enq_mask[k] is the one-hot mask of the k-th lowest-index entry with valid=0, taken from the registered valid bits only.
  - enq_rdy_o[k] is the OR of enq_mask[k].
  - Port k maps to its slot statically, whether or not lower ports are valid.
  - Enqueue fire on port k = enq_vld_i[k] AND enq_rdy_o[k]. On fire, the slot's valid and payload are written at the next edge.
- Issue selection:
  - Candidates are entry_vld AND entry_rdy_i.
  - result_mask[j] is the j-th lowest-index candidate.
  - deq_vld_o[j] is the OR of result_mask[j]; deq_data_o and deq_idx_o are muxed from result_mask[j], and are 0 when deq_vld_o[j]=0.
  - Issue fire on port j = deq_vld_o[j] AND deq_rdy_i[j]; the entry's valid bit clears at the next edge.
  - Ports are independent: port 1 may fire while port 0 stalls.
- Path latency:
  - Enqueue-to-issue latency is at least 1 cycle: an entry written at edge N is first selectable in the cycle after edge N.
  - Enqueue, select and issue paths are combinational from the registered state; there is no combinational path from enq_vld_i to deq_vld_o.
- No-hold semantics: deq_vld_o and deq_data_o may change, or drop, without a fire. For example, when a lower-index entry becomes ready it takes over port 0. Consumers must not assume stickiness.
- Same-cycle enqueue and issue:
  - A slot freed by an issue fire is not reusable in the same cycle; it becomes allocatable the cycle after.
  - Therefore enqueue and dequeue never target the same slot in one cycle.
  - count_next = count + popcount(enq fires) - popcount(issue fires).
- Flush:
  - flush_i=1 clears all valid bits at the next edge and sets count to 0.
  - Flush takes priority over same-cycle enqueue fires, which are dropped.
  - During a flush cycle the outputs still reflect current state; consumers ignore issue fires in that cycle.
- Full: enq_rdy_o=0 on every port and enq_vld_i is ignored. Partial space: with F free slots, ports 0..F-1 are ready and ports F..EnqWidth-1 are not.
- Empty: deq_vld_o=0 on every port regardless of entry_rdy_i.
- entry_rdy_i bits for invalid entries are ignored.

Test Plan:
- Reset then fill (Depth=8, EnqWidth=2, SelWidth=2): enqueue 4 cycles with both ports valid and entry_rdy_i=0 -> entry_vld_o=8'hFF, count_o=8, full_o=1, enq_rdy_o=2'b00, deq_vld_o=0.
- Issue priority: valid=8'hFF, entry_rdy_i=8'b0101_0100, deq_rdy_i=2'b11 -> deq_idx_o = {4, 2}; next cycle valid=8'hEB and port0 idx=6; count drops 8 -> 6.
- Fragmented allocation: valid=8'b1011_0110, enq_vld_i=2'b11 -> data written to slots 0 and 3; valid becomes 8'hBF; enq_rdy_o is 2'b01 the next cycle.
- Same-cycle free and alloc: valid=8'hFE, entry 5 issues while port 0 enqueues -> slot 0 is written, slot 5 stays unavailable that cycle, count stays 7; next cycle enq_rdy_o[0]=1 mapped to slot 5.
- Stall independence: two ready entries, deq_rdy_i=2'b10 -> only port-1 entry clears; port 0 re-presents the same idx next cycle.
- Flush with enqueue plus async reset: flush_i=1 with enq_vld_i=2'b11 at count 5 -> count_o=0, empty_o=1 next cycle with no enqueue retained; then assert rst_n=0 mid-fill -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/static_priority_issue_queue.sv
// Multi-port issue queue: allocates the lowest-index free slots for enqueue
// and issues the lowest-index valid-and-ready entries on each select port.
module static_priority_issue_queue #(
    parameter int Depth     = 8,
    parameter int EnqWidth  = 2,
    parameter int SelWidth  = 2,
    parameter int DataWidth = 32,
    parameter int PtrWidth  = $clog2(Depth)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [EnqWidth-1:0]           enq_vld_i,
    input  logic [EnqWidth*DataWidth-1:0] enq_data_i,
    output logic [EnqWidth-1:0]           enq_rdy_o,
    input  logic [Depth-1:0]              entry_rdy_i,
    output logic [SelWidth-1:0]           deq_vld_o,
    input  logic [SelWidth-1:0]           deq_rdy_i,
    output logic [SelWidth*DataWidth-1:0] deq_data_o,
    output logic [SelWidth*PtrWidth-1:0]  deq_idx_o,
    output logic [Depth-1:0]              entry_vld_o,
    output logic [PtrWidth:0]             count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    logic [Depth-1:0]     valid;
    logic [DataWidth-1:0] payload [Depth];

    logic [Depth-1:0]     enq_mask [EnqWidth];
    logic [Depth-1:0]     sel_mask [SelWidth];
    logic [EnqWidth-1:0]  enq_fire;
    logic [SelWidth-1:0]  deq_fire;
    logic [Depth-1:0]     set_mask;
    logic [Depth-1:0]     clr_mask;

    // Port k owns the k-th free slot, regardless of which ports are requesting.
    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < EnqWidth; k++) enq_mask[k] = '0;
        for (int i = 0; i < Depth; i++) begin
            if (!valid[i]) begin
                for (int k = 0; k < EnqWidth; k++)
                    if (n == k) enq_mask[k][i] = 1'b1;
                n = n + 1;
            end
        end
    end

    always_comb begin
        int n;
        n = 0;
        for (int j = 0; j < SelWidth; j++) sel_mask[j] = '0;
        for (int i = 0; i < Depth; i++) begin
            if (valid[i] && entry_rdy_i[i]) begin
                for (int j = 0; j < SelWidth; j++)
                    if (n == j) sel_mask[j][i] = 1'b1;
                n = n + 1;
            end
        end
    end

    always_comb begin
        deq_vld_o  = '0;
        deq_data_o = '0;
        deq_idx_o  = '0;
        for (int j = 0; j < SelWidth; j++) begin
            deq_vld_o[j] = |sel_mask[j];
            for (int i = 0; i < Depth; i++) begin
                if (sel_mask[j][i]) begin
                    deq_data_o[j*DataWidth +: DataWidth] = payload[i];
                    deq_idx_o[j*PtrWidth +: PtrWidth]    = PtrWidth'(i);
                end
            end
        end
    end

    always_comb begin
        enq_fire = '0;
        set_mask = '0;
        for (int k = 0; k < EnqWidth; k++) begin
            enq_rdy_o[k] = |enq_mask[k];
            enq_fire[k]  = enq_vld_i[k] & enq_rdy_o[k];
            if (enq_fire[k]) set_mask = set_mask | enq_mask[k];
        end
    end

    always_comb begin
        deq_fire = deq_vld_o & deq_rdy_i;
        clr_mask = '0;
        for (int j = 0; j < SelWidth; j++)
            if (deq_fire[j]) clr_mask = clr_mask | sel_mask[j];
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < Depth; i++)
            count_o = count_o + (PtrWidth+1)'(valid[i]);
    end

    assign entry_vld_o = valid;
    assign full_o      = (count_o == (PtrWidth+1)'(Depth));
    assign empty_o     = (count_o == '0);

    // Enqueue only targets free slots and issue only valid ones, so set and
    // clear masks never overlap; flush wins over any same-cycle enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < Depth; i++) payload[i] <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else begin
            valid <= (valid & ~clr_mask) | set_mask;
            for (int k = 0; k < EnqWidth; k++)
                for (int i = 0; i < Depth; i++)
                    if (enq_fire[k] && enq_mask[k][i])
                        payload[i] <= enq_data_i[k*DataWidth +: DataWidth];
        end
    end

endmodule

// File: tb/tb_static_priority_issue_queue.sv
// Directed testbench for static_priority_issue_queue (Depth=8, 2 enq, 2 sel).
module tb_static_priority_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  enq_vld_i;
    logic [63:0] enq_data_i;
    logic [1:0]  enq_rdy_o;
    logic [7:0]  entry_rdy_i;
    logic [1:0]  deq_vld_o;
    logic [1:0]  deq_rdy_i;
    logic [63:0] deq_data_o;
    logic [5:0]  deq_idx_o;
    logic [7:0]  entry_vld_o;
    logic [3:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int checks = 0;
    int errors = 0;

    static_priority_issue_queue #(
        .Depth(8), .EnqWidth(2), .SelWidth(2), .DataWidth(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .enq_vld_i(enq_vld_i), .enq_data_i(enq_data_i), .enq_rdy_o(enq_rdy_o),
        .entry_rdy_i(entry_rdy_i), .deq_vld_o(deq_vld_o), .deq_rdy_i(deq_rdy_i),
        .deq_data_o(deq_data_o), .deq_idx_o(deq_idx_o), .entry_vld_o(entry_vld_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        enq_vld_i   = 2'b00;
        enq_data_i  = '0;
        entry_rdy_i = 8'h00;
        deq_rdy_i   = 2'b00;
    endtask

    // Fills an empty queue: slot i receives 32'hA000_0000 + i.
    task automatic fill_all();
        for (int c = 0; c < 4; c++) begin
            enq_vld_i  = 2'b11;
            enq_data_i = {32'hA000_0000 + 32'(2*c+1), 32'hA000_0000 + 32'(2*c)};
            step();
        end
        enq_vld_i = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        entry_rdy_i = 8'hFF;
        rst_n = 1'b0;
        #12;
        checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", full_o); end
        checks++; if (deq_vld_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_deq_vld got %b want 00", deq_vld_o); end
        checks++; if (deq_data_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_deq_data got %h want 0", deq_data_o); end
        checks++; if (deq_idx_o !== 6'h0) begin errors++; $display("[TB] FAIL reset_deq_idx got %h want 0", deq_idx_o); end
        checks++; if (enq_rdy_o !== 2'b11) begin errors++; $display("[TB] FAIL reset_enq_rdy got %b want 11", enq_rdy_o); end
        checks++; if (entry_vld_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_entry_vld got %h want 00", entry_vld_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        entry_rdy_i = 8'h00;
        #1;
    endtask

    task automatic test_fill();
        fill_all();
        checks++; if (entry_vld_o !== 8'hFF) begin errors++; $display("[TB] FAIL fill_entry_vld got %h want FF", entry_vld_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("[TB] FAIL fill_count got %0d want 8", count_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %0b want 1", full_o); end
        checks++; if (enq_rdy_o !== 2'b00) begin errors++; $display("[TB] FAIL fill_enq_rdy got %b want 00", enq_rdy_o); end
        checks++; if (deq_vld_o !== 2'b00) begin errors++; $display("[TB] FAIL fill_deq_vld got %b want 00", deq_vld_o); end
        enq_vld_i  = 2'b11;
        enq_data_i = {32'hDEAD_0001, 32'hDEAD_0000};
        step();
        enq_vld_i = 2'b00;
        checks++; if (count_o !== 4'd8) begin errors++; $display("[TB] FAIL full_ignore_count got %0d want 8", count_o); end
    endtask

    task automatic test_issue_priority();
        entry_rdy_i = 8'b0101_0100;
        deq_rdy_i   = 2'b11;
        #1;
        checks++; if (deq_vld_o !== 2'b11) begin errors++; $display("[TB] FAIL prio_deq_vld got %b want 11", deq_vld_o); end
        checks++; if (deq_idx_o !== {3'd4, 3'd2}) begin errors++; $display("[TB] FAIL prio_deq_idx got %o want 42", deq_idx_o); end
        checks++; if (deq_data_o !== {32'hA000_0004, 32'hA000_0002}) begin errors++; $display("[TB] FAIL prio_deq_data got %h want a0000004a0000002", deq_data_o); end
        step();
        deq_rdy_i = 2'b00;
        #1;
        checks++; if (entry_vld_o !== 8'hEB) begin errors++; $display("[TB] FAIL prio_after_vld got %h want EB", entry_vld_o); end
        checks++; if (count_o !== 4'd6) begin errors++; $display("[TB] FAIL prio_after_count got %0d want 6", count_o); end
        checks++; if (deq_idx_o[2:0] !== 3'd6) begin errors++; $display("[TB] FAIL prio_after_idx0 got %0d want 6", deq_idx_o[2:0]); end
        checks++; if (deq_vld_o !== 2'b01) begin errors++; $display("[TB] FAIL prio_after_deq_vld got %b want 01", deq_vld_o); end
        checks++; if (deq_data_o[63:32] !== 32'h0) begin errors++; $display("[TB] FAIL prio_idle_port1_data got %h want 0", deq_data_o[63:32]); end
        entry_rdy_i = 8'h00;
    endtask

    task automatic test_fragmented();
        do_reset();
        fill_all();
        entry_rdy_i = 8'b0000_1001;
        deq_rdy_i   = 2'b11;
        step();
        entry_rdy_i = 8'b0100_0000;
        deq_rdy_i   = 2'b01;
        step();
        entry_rdy_i = 8'h00;
        deq_rdy_i   = 2'b00;
        #1;
        checks++; if (entry_vld_o !== 8'hB6) begin errors++; $display("[TB] FAIL frag_setup_vld got %h want B6", entry_vld_o); end
        checks++; if (enq_rdy_o !== 2'b11) begin errors++; $display("[TB] FAIL frag_enq_rdy got %b want 11", enq_rdy_o); end
        enq_vld_i  = 2'b11;
        enq_data_i = {32'hC000_0001, 32'hC000_0000};
        step();
        enq_vld_i = 2'b00;
        entry_rdy_i = 8'b0000_1001;
        #1;
        checks++; if (entry_vld_o !== 8'hBF) begin errors++; $display("[TB] FAIL frag_vld got %h want BF", entry_vld_o); end
        checks++; if (enq_rdy_o !== 2'b01) begin errors++; $display("[TB] FAIL frag_enq_rdy_after got %b want 01", enq_rdy_o); end
        checks++; if (deq_idx_o !== {3'd3, 3'd0}) begin errors++; $display("[TB] FAIL frag_slot_idx got %o want 30", deq_idx_o); end
        checks++; if (deq_data_o !== {32'hC000_0001, 32'hC000_0000}) begin errors++; $display("[TB] FAIL frag_slot_data got %h want c0000001c0000000", deq_data_o); end
        entry_rdy_i = 8'h00;
    endtask

    task automatic test_same_cycle();
        do_reset();
        fill_all();
        entry_rdy_i = 8'h01;
        deq_rdy_i   = 2'b01;
        step();
        entry_rdy_i = 8'b0010_0000;
        enq_vld_i   = 2'b01;
        enq_data_i  = {32'h0, 32'hD000_0000};
        #1;
        checks++; if (entry_vld_o !== 8'hFE) begin errors++; $display("[TB] FAIL same_setup_vld got %h want FE", entry_vld_o); end
        checks++; if (enq_rdy_o !== 2'b01) begin errors++; $display("[TB] FAIL same_enq_rdy got %b want 01", enq_rdy_o); end
        checks++; if (deq_idx_o[2:0] !== 3'd5) begin errors++; $display("[TB] FAIL same_deq_idx got %0d want 5", deq_idx_o[2:0]); end
        step();
        deq_rdy_i   = 2'b00;
        entry_rdy_i = 8'h00;
        enq_vld_i   = 2'b00;
        #1;
        checks++; if (entry_vld_o !== 8'hDF) begin errors++; $display("[TB] FAIL same_vld got %h want DF", entry_vld_o); end
        checks++; if (count_o !== 4'd7) begin errors++; $display("[TB] FAIL same_count got %0d want 7", count_o); end
        checks++; if (enq_rdy_o !== 2'b01) begin errors++; $display("[TB] FAIL same_enq_rdy_next got %b want 01", enq_rdy_o); end
        enq_vld_i  = 2'b01;
        enq_data_i = {32'h0, 32'hD000_0005};
        step();
        enq_vld_i   = 2'b00;
        entry_rdy_i = 8'b0010_0000;
        #1;
        checks++; if (entry_vld_o !== 8'hFF) begin errors++; $display("[TB] FAIL same_reuse_vld got %h want FF", entry_vld_o); end
        checks++; if (deq_data_o[31:0] !== 32'hD000_0005) begin errors++; $display("[TB] FAIL same_reuse_data got %h want d0000005", deq_data_o[31:0]); end
        entry_rdy_i = 8'h00;
    endtask

    task automatic test_stall();
        entry_rdy_i = 8'b0000_0011;
        deq_rdy_i   = 2'b10;
        #1;
        checks++; if (deq_idx_o !== {3'd1, 3'd0}) begin errors++; $display("[TB] FAIL stall_idx got %o want 10", deq_idx_o); end
        step();
        deq_rdy_i = 2'b00;
        #1;
        checks++; if (entry_vld_o !== 8'hFD) begin errors++; $display("[TB] FAIL stall_vld got %h want FD", entry_vld_o); end
        checks++; if (deq_vld_o !== 2'b01) begin errors++; $display("[TB] FAIL stall_deq_vld got %b want 01", deq_vld_o); end
        checks++; if (deq_idx_o[2:0] !== 3'd0) begin errors++; $display("[TB] FAIL stall_represent_idx got %0d want 0", deq_idx_o[2:0]); end
        checks++; if (deq_data_o[31:0] !== 32'hD000_0000) begin errors++; $display("[TB] FAIL stall_represent_data got %h want d0000000", deq_data_o[31:0]); end
        entry_rdy_i = 8'h00;
    endtask

    task automatic test_flush();
        entry_rdy_i = 8'b0000_1100;
        deq_rdy_i   = 2'b11;
        step();
        entry_rdy_i = 8'h00;
        deq_rdy_i   = 2'b00;
        #1;
        checks++; if (count_o !== 4'd5) begin errors++; $display("[TB] FAIL flush_setup_count got %0d want 5", count_o); end
        flush_i    = 1'b1;
        enq_vld_i  = 2'b11;
        enq_data_i = {32'hEEEE_0001, 32'hEEEE_0000};
        step();
        flush_i   = 1'b0;
        enq_vld_i = 2'b00;
        #1;
        checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got %0b want 1", empty_o); end
        checks++; if (entry_vld_o !== 8'h00) begin errors++; $display("[TB] FAIL flush_vld got %h want 00", entry_vld_o); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            enq_vld_i  = 2'b11;
            enq_data_i = {32'hF000_0001 + 32'(2*c), 32'hF000_0000 + 32'(2*c)};
            step();
        end
        entry_rdy_i = 8'hFF;
        #1;
        checks++; if (count_o !== 4'd4) begin errors++; $display("[TB] FAIL async_setup_count got %0d want 4", count_o); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL async_count got %0d want 0", count_o); end
        checks++; if (entry_vld_o !== 8'h00) begin errors++; $display("[TB] FAIL async_vld got %h want 00", entry_vld_o); end
        checks++; if (deq_vld_o !== 2'b00) begin errors++; $display("[TB] FAIL async_deq_vld got %b want 00", deq_vld_o); end
        checks++; if (deq_data_o !== 64'h0) begin errors++; $display("[TB] FAIL async_deq_data got %h want 0", deq_data_o); end
        step();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("[TB] FAIL async_hold_empty got %0b want 1", empty_o); end
        rst_n = 1'b1;
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fill();
        test_issue_priority();
        test_fragmented();
        test_same_cycle();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
